// File: rtl/cg_rvarch_regfile_wbarb.sv
// Two-requester register-file write-back arbiter with alternating tie priority
// and a per-register pending-write scoreboard.
//
// state | meaning
// PRI0  | requester 0 (ALU path) wins a tie
// PRI1  | requester 1 (load path) wins a tie
module cg_rvarch_regfile_wbarb #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_NUM   = 32,
  localparam int AW         = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [AW-1:0]         i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [AW-1:0]         i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  input  logic                  i_issue_valid,
  input  logic [AW-1:0]         i_issue_addr,
  output logic [DATA_NUM-1:0]   o_busy,
  output logic                  o_rd_we,
  output logic [AW-1:0]         o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  rd_we_q, rd_we_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_NUM-1:0]   busy_q, busy_d;

  logic                  grant0, grant1, xfer;
  logic [AW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | (state_q == PRI0));
    grant1 = i_req1_valid & (~i_req0_valid | (state_q == PRI1));
    xfer   = grant0 | grant1;
    waddr  = grant1 ? i_req1_addr : i_req0_addr;
    wdata  = grant1 ? i_req1_data : i_req0_data;

    state_d = state_q;
    if (grant0)      state_d = PRI1;
    else if (grant1) state_d = PRI0;

    // x0 writes are consumed (and rotate priority) but never reach the file
    rd_we_d   = xfer && (waddr != '0);
    rd_addr_d = xfer ? waddr : rd_addr_q;
    rd_data_d = xfer ? wdata : rd_data_q;

    // clear first so a coincident issue to the same register wins
    busy_d = busy_q;
    if (rd_we_d) busy_d[waddr] = 1'b0;
    if (i_issue_valid && (i_issue_addr != '0)) busy_d[i_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= PRI0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  // ready is forced low while reset is held so no handshake completes then
  assign o_req0_ready = grant0 & i_rst_n;
  assign o_req1_ready = grant1 & i_rst_n;
  assign o_rd_we      = rd_we_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_rd_data    = rd_data_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/cg_rvarch_regfile_wbarb.md
CG_RVARCH_REGFILE_WBARB -- requirements
Module: cg_rvarch_regfile_wbarb

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the register data width.
REQ-002 The module SHALL have parameter DATA_NUM, default 32, the number of architectural registers; the address width is clog2(DATA_NUM).
REQ-003 Port i_clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-005 Ports i_req0_valid (in, 1), o_req0_ready (out, 1), i_req0_addr (in, AW), i_req0_data (in, DATA_WIDTH) SHALL form write-back requester 0 (ALU path).
REQ-006 Ports i_req1_valid (in, 1), o_req1_ready (out, 1), i_req1_addr (in, AW), i_req1_data (in, DATA_WIDTH) SHALL form write-back requester 1 (load path).
REQ-007 Ports i_issue_valid (in, 1) and i_issue_addr (in, AW) SHALL mark a destination register as pending.
REQ-008 Port o_busy, output, DATA_NUM bits, SHALL give the per-register pending-write scoreboard.
REQ-009 Ports o_rd_we (out, 1), o_rd_addr (out, AW), o_rd_data (out, DATA_WIDTH) SHALL drive the register file write port directly.

Function
REQ-010 Arbiter SHALL be a two-state FSM: PRI0 (requester 0 wins ties) and PRI1 (requester 1 wins ties).
REQ-011 With exactly one valid request, the arbiter SHALL grant it regardless of state.
REQ-012 With both valid, the arbiter SHALL grant the requester favoured by the current state.
REQ-013 o_reqN_ready SHALL be combinational and equal to the grant for N; at most one ready is high per cycle; ready is low when the matching valid is low.
REQ-014 A transfer SHALL occur on a cycle where valid and ready are both high.
REQ-015 After a transfer from requester 0 the state SHALL become PRI1; after a transfer from requester 1 it SHALL become PRI0; with no transfer the state SHALL hold.
REQ-016 A transfer accepted at edge N SHALL appear on o_rd_we/o_rd_addr/o_rd_data as registered outputs, valid for the cycle following edge N (one-cycle latency).
REQ-017 With no transfer, o_rd_we SHALL be 0 the following cycle; o_rd_addr/o_rd_data SHALL hold their last values.
REQ-018 A transfer with address 0 SHALL be accepted and SHALL update the FSM, but SHALL NOT assert o_rd_we.
REQ-019 A requester SHALL hold valid, addr and data stable until accepted; the block does not buffer unaccepted requests.
REQ-020 i_issue_valid with a nonzero address i SHALL set o_busy[i] at the next edge.
REQ-021 Bit o_busy[i] SHALL clear at the edge where the write to i is registered onto the write port (the same edge o_rd_we=1, o_rd_addr=i appears).
REQ-022 If a set and a clear target the same register at the same edge, the set SHALL win and o_busy[i] SHALL remain 1.
REQ-023 o_busy[0] SHALL be constantly 0; issue to address 0 SHALL be ignored.
REQ-024 A write to a register whose busy bit is 0 SHALL still be performed.

Reset
REQ-025 While i_rst_n=0, outputs SHALL be: o_rd_we=0, o_rd_addr=0, o_rd_data=0, o_busy=0; the FSM SHALL be in PRI0.
REQ-026 A reset asserted mid-operation SHALL immediately discard any registered write (o_rd_we=0 asynchronously) and clear every busy bit.
REQ-027 o_reqN_ready SHALL be 0 during reset.
REQ-028 The first edge after i_rst_n rises SHALL arbitrate normally from PRI0.

Verification
REQ-029 Single request: req0 addr=1, data=0x0810 -> ready0=1 that cycle; next cycle o_rd_we=1, o_rd_addr=1, o_rd_data=0x0810.
REQ-030 Tie after reset: both valid (req0 addr=2/0x514, req1 addr=3/0xABC), held -> cycle 1 grants req0, cycle 2 grants req1; write port shows reg2 then reg3 on consecutive cycles.
REQ-031 Fairness: both valid continuously for 8 cycles -> grants alternate 0,1,0,1,...; each requester gets exactly 4.
REQ-032 x0 drop: req1 addr=0, data=0xFFFF_FFFF -> ready1=1; o_rd_we stays 0; next tie goes to req0.
REQ-033 Scoreboard: issue addr=5 -> o_busy[5]=1; write to 5 via req1 -> busy[5] clears on the edge o_rd_we appears; issue 5 coinciding with that edge -> busy[5] stays 1; issue addr=0 -> o_busy stays 0.
REQ-034 Reset mid-op: busy[7]=1 and a write in flight, pull i_rst_n low between edges -> o_rd_we=0 and o_busy=0 without a clock edge; after release, a tie grants req0.
